// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer for a single-port RAM: one command per grant, two cycles per access.
// Define RAMARB_FIXED_PRIO_EN for fixed A-over-B priority; default is round-robin.
module ram_port_arbiter #(
    parameter int AW = 10,
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_done,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_done,
    output logic [DW-1:0] b_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic          ownerB_q, ownerB_d;
    logic          ramWe_q, ramWe_d;
    logic [AW-1:0] ramAddr_q, ramAddr_d;
    logic [DW-1:0] ramWdata_q, ramWdata_d;
    logic          aGnt_q, aGnt_d, bGnt_q, bGnt_d;
    logic          aDone_q, aDone_d, bDone_q, bDone_d;
    logic [DW-1:0] aRdata_q, aRdata_d, bRdata_q, bRdata_d;
    logic          pickB;

`ifdef RAMARB_FIXED_PRIO_EN
    assign pickB = ~a_req;
`else
    // lastB_q remembers who won last; it starts at B so A wins the first tie.
    logic lastB_q;

    assign pickB = b_req & (~a_req | ~lastB_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastB_q <= 1'b1;
        end else if (state_q == IDLE && (a_req || b_req)) begin
            lastB_q <= pickB;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ownerB_q   <= 1'b0;
            ramWe_q    <= 1'b0;
            ramAddr_q  <= '0;
            ramWdata_q <= '0;
            aGnt_q     <= 1'b0;
            bGnt_q     <= 1'b0;
            aDone_q    <= 1'b0;
            bDone_q    <= 1'b0;
            aRdata_q   <= '0;
            bRdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            ownerB_q   <= ownerB_d;
            ramWe_q    <= ramWe_d;
            ramAddr_q  <= ramAddr_d;
            ramWdata_q <= ramWdata_d;
            aGnt_q     <= aGnt_d;
            bGnt_q     <= bGnt_d;
            aDone_q    <= aDone_d;
            bDone_q    <= bDone_d;
            aRdata_q   <= aRdata_d;
            bRdata_q   <= bRdata_d;
        end
    end

    // The RAM port registers double as the command latch; the address and data hold in IDLE.
    always_comb begin
        state_d    = state_q;
        ownerB_d   = ownerB_q;
        ramWe_d    = 1'b0;
        ramAddr_d  = ramAddr_q;
        ramWdata_d = ramWdata_q;
        aGnt_d     = 1'b0;
        bGnt_d     = 1'b0;
        aDone_d    = 1'b0;
        bDone_d    = 1'b0;
        aRdata_d   = aRdata_q;
        bRdata_d   = bRdata_q;
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    state_d    = ACCESS;
                    ownerB_d   = pickB;
                    ramWe_d    = pickB ? b_we    : a_we;
                    ramAddr_d  = pickB ? b_addr  : a_addr;
                    ramWdata_d = pickB ? b_wdata : a_wdata;
                    aGnt_d     = ~pickB;
                    bGnt_d     = pickB;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (ownerB_q) begin
                    bDone_d = 1'b1;
                    if (!ramWe_q) bRdata_d = ram_rdata;
                end else begin
                    aDone_d = 1'b1;
                    if (!ramWe_q) aRdata_d = ram_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign a_gnt       = aGnt_q;
    assign b_gnt       = bGnt_q;
    assign a_done      = aDone_q;
    assign b_done      = bDone_q;
    assign a_rdata     = aRdata_q;
    assign b_rdata     = bRdata_q;
    assign ram_we      = ramWe_q;
    assign ram_address = ramAddr_q;
    assign ram_wdata   = ramWdata_q;
    assign busy        = (state_q == ACCESS);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural 1024x10 RAM and per-requester read-data scoreboards.
module tb_ram_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, a_done, b_gnt, b_done, ram_we, busy;
    logic [DW-1:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_address;

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_address(ram_address), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    // Behavioural RAM: asynchronous read, synchronous write, preloaded on the first clock edge.
    logic [DW-1:0] mem [1024];
    bit memInit = 1'b0;
    assign ram_rdata = mem[ram_address];
    always @(posedge clk) begin
        if (!memInit) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem[0] <= 10'h005;
            mem[6] <= 10'h057;
            mem[7] <= 10'h061;
            mem[8] <= 10'h0AB;
            mem[9] <= 10'h1CD;
            memInit <= 1'b1;
        end else if (ram_we) begin
            mem[ram_address] <= ram_wdata;
        end
    end

    int cmpCount = 0;
    int failCount = 0;
    int cycleCount = 0;
    logic [DW-1:0] aQ[$];
    logic [DW-1:0] bQ[$];
    bit gntLog[$];
    int gntCycleA[$];

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        cmpCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Per-cycle monitor: protocol invariants, grant log, and scoreboard pops on done pulses.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("single_gnt", 32'(a_gnt & b_gnt), 32'd0);
            checkOutput("we_outside_access", 32'(ram_we & ~busy), 32'd0);
            if (a_gnt) begin
                gntLog.push_back(1'b0);
                gntCycleA.push_back(cycleCount);
            end
            if (b_gnt) gntLog.push_back(1'b1);
            if (a_done) begin
                cmpCount++;
                if (aQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL a_done_unexpected: got a_done=1 rdata 0x%0h, expected no done", a_rdata);
                end else begin
                    cmpCount--;
                    checkOutput("a_rdata_sb", 32'(a_rdata), 32'(aQ.pop_front()));
                end
            end
            if (b_done) begin
                cmpCount++;
                if (bQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL b_done_unexpected: got b_done=1 rdata 0x%0h, expected no done", b_rdata);
                end else begin
                    cmpCount--;
                    checkOutput("b_rdata_sb", 32'(b_rdata), 32'(bQ.pop_front()));
                end
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_gnt"}, 32'({a_gnt, b_gnt}), 32'd0);
        checkOutput({tag, "_done"}, 32'({a_done, b_done}), 32'd0);
        checkOutput({tag, "_a_rdata"}, 32'(a_rdata), 32'd0);
        checkOutput({tag, "_b_rdata"}, 32'(b_rdata), 32'd0);
        checkOutput({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        checkOutput({tag, "_ram_address"}, 32'(ram_address), 32'd0);
        checkOutput({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        bit            isB;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] expRdata;
    } vec_t;

    // One isolated transaction: grant at t+1 with the command on the RAM port, done at t+2.
    task automatic applyStimulus(input vec_t v, input logic [DW-1:0] otherRdata);
        @(posedge clk); #1;
        if (v.isB) begin
            bQ.push_back(v.expRdata);
            b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
        end else begin
            aQ.push_back(v.expRdata);
            a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
        end
        @(posedge clk); #1;
        checkOutput("vec_gnt", 32'(v.isB ? b_gnt : a_gnt), 32'd1);
        checkOutput("vec_other_gnt", 32'(v.isB ? a_gnt : b_gnt), 32'd0);
        checkOutput("vec_early_done", 32'({a_done, b_done}), 32'd0);
        checkOutput("vec_busy", 32'(busy), 32'd1);
        checkOutput("vec_ram_address", 32'(ram_address), 32'(v.addr));
        checkOutput("vec_ram_we", 32'(ram_we), 32'(v.we));
        if (v.we) checkOutput("vec_ram_wdata", 32'(ram_wdata), 32'(v.wdata));
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("vec_done", 32'(v.isB ? b_done : a_done), 32'd1);
        checkOutput("vec_other_done", 32'(v.isB ? a_done : b_done), 32'd0);
        checkOutput("vec_other_rdata", 32'(v.isB ? a_rdata : b_rdata), 32'(otherRdata));
        checkOutput("vec_idle_busy", 32'({busy, ram_we}), 32'd0);
    endtask

    initial begin
        vec_t vecs[9];
        logic [DW-1:0] expA;
        logic [DW-1:0] expB;
        bit expGnt[5];
        int waitCnt;

        vecs[0] = '{1'b0, 1'b0, 10'd0,    10'h000, 10'h005};
        vecs[1] = '{1'b1, 1'b0, 10'd6,    10'h000, 10'h057};
        vecs[2] = '{1'b1, 1'b1, 10'd25,   10'h2AA, 10'h057};
        vecs[3] = '{1'b0, 1'b0, 10'd25,   10'h000, 10'h2AA};
        vecs[4] = '{1'b0, 1'b1, 10'd1023, 10'h155, 10'h2AA};
        vecs[5] = '{1'b1, 1'b0, 10'd1023, 10'h000, 10'h155};
        vecs[6] = '{1'b0, 1'b0, 10'd7,    10'h000, 10'h061};
        vecs[7] = '{1'b1, 1'b1, 10'd2,    10'h3FF, 10'h155};
        vecs[8] = '{1'b0, 1'b0, 10'd2,    10'h000, 10'h3FF};

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("por");
        reset = 1'b0;

        // Both requesters hold req: default round-robin alternates A,B; fixed priority starves B.
`ifdef RAMARB_FIXED_PRIO_EN
        expGnt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        repeat (4) aQ.push_back(10'h057);
        bQ.push_back(10'h005);
`else
        expGnt = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        repeat (2) aQ.push_back(10'h057);
        repeat (3) bQ.push_back(10'h005);
`endif
        gntLog.delete();
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'd6;
        b_req = 1'b1; b_we = 1'b0; b_addr = 10'd0;
        waitCnt = 0;
        while (gntLog.size() < 4 && waitCnt < 30) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        a_req = 1'b0;
        while (gntLog.size() < 5 && waitCnt < 40) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        b_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("alt_gnt_count", 32'(gntLog.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < gntLog.size()) checkOutput("alt_gnt_order", 32'(gntLog[i]), 32'(expGnt[i]));
        end
        checkOutput("alt_a_rdata", 32'(a_rdata), 32'h057);
        checkOutput("alt_b_rdata", 32'(b_rdata), 32'h005);

        expA = 10'h057;
        expB = 10'h005;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], vecs[i].isB ? expA : expB);
            if (vecs[i].isB) expB = vecs[i].expRdata;
            else             expA = vecs[i].expRdata;
        end

        // Back-to-back: A keeps req high and switches the address as soon as it sees the first grant.
        gntCycleA.delete();
        aQ.push_back(10'h0AB);
        aQ.push_back(10'h1CD);
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'd8;
        waitCnt = 0;
        do begin
            @(posedge clk); #1;
            waitCnt++;
        end while (a_gnt !== 1'b1 && waitCnt < 10);
        a_addr = 10'd9;
        do begin
            @(posedge clk); #1;
            waitCnt++;
        end while (a_gnt !== 1'b1 && waitCnt < 20);
        a_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("b2b_gnt_count", 32'(gntCycleA.size()), 32'd2);
        if (gntCycleA.size() == 2)
            checkOutput("b2b_gnt_spacing", 32'(gntCycleA[1] - gntCycleA[0]), 32'd2);
        checkOutput("b2b_a_rdata", 32'(a_rdata), 32'h1CD);

        // Reset lands in the ACCESS cycle of a B write: the write and its done must vanish.
        @(posedge clk); #1;
        b_req = 1'b1; b_we = 1'b1; b_addr = 10'd7; b_wdata = 10'h3FF;
        @(posedge clk); #1;
        checkOutput("rst_b_gnt", 32'(b_gnt), 32'd1);
        checkOutput("rst_ram_we_before", 32'(ram_we), 32'd1);
        b_req = 1'b0;
        b_we = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkResetOutputs("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        applyStimulus('{1'b0, 1'b0, 10'd7, 10'h000, 10'h061}, 10'h000);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("a_queue_drained", 32'(aQ.size()), 32'd0);
        checkOutput("b_queue_drained", 32'(bQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the team's single-port 1024x10 RAM (asynchronous read, synchronous write on posedge clk).
- Lets two masters share the one RAM port, e.g. the control FSM and a string-walker engine reading null-terminated character tables.
- Latches one command per grant and drives the RAM port for exactly one cycle.
- Returns registered read data with a done pulse.

Parameters:
- AW, 10, address width; RAM depth 2**AW.
- DW, 10, data width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- a_req  input  1  requester A access request, level.
- a_we  input  1  A: 1 = write, 0 = read.
- a_addr  input  AW  A address.
- a_wdata  input  DW  A write data.
- a_gnt  output  1  A command accepted, 1-cycle pulse.
- a_done  output  1  A access complete, 1-cycle pulse.
- a_rdata  output  DW  A read data, valid with a_done on reads.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: same as A, for requester B.
- ram_we  output  1  RAM write enable.
- ram_address  output  AW  RAM address.
- ram_wdata  output  DW  RAM write data.
- ram_rdata  input  DW  RAM asynchronous read data.
- busy  output  1  high while in ACCESS.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. All outputs 0: gnt, done, rdata, ram_we, ram_address, ram_wdata, busy. Round-robin pointer last=B, so A wins the first tie.
- FSM states: IDLE, ACCESS. Each transaction takes 2 cycles; maximum throughput is one access per 2 cycles.
- IDLE, cycle t, if any req sampled high:
  - Select winner: only one requesting -> that one; both requesting -> the one not equal to last.
  - Latch winner's we/addr/wdata into cmd registers; set last=winner.
  - Go to ACCESS; winner's gnt=1 during t+1 (registered).
- IDLE with no req: stay in IDLE; no outputs change except the done pulses clearing.
- ACCESS, cycle t+1:
  - busy=1; ram_address=cmd_addr; ram_wdata=cmd_wdata; ram_we=cmd_we.
  - These are registered outputs, set on the t edge.
  - Write commits at the end of t+1.
  - Read: ram_rdata captured into winner's rdata at the end of t+1.
  - Always returns to IDLE.
- Cycle t+2: winner's done=1 for one cycle; rdata holds the captured value until the next read completion for that requester.
  - Writes pulse done but leave rdata unchanged.
  - ram_we=0 and busy=0 in IDLE; ram_address/ram_wdata hold their last values.
- Requests are not sampled in ACCESS. Requester holds req/addr/we/wdata stable until gnt.
  - A req still high in t+2 is treated as a new request, so its command fields must be valid then.
  - Requester deasserts req in the cycle gnt is seen if no further access is wanted.
- Cycle t+2 may begin a new grant: done of the previous access and gnt of the next coincide at t+3? No. The new grant appears at t+3, while done appears at t+2.
- The other requester's gnt/done/rdata never change during a transaction.
- No simultaneous grants: at most one gnt high per cycle. ram_we is never high outside ACCESS.
- Addresses use the full AW range, 0..2**AW-1, with no wrap or bounds logic.
- Reset mid-ACCESS: pending access is dropped. ram_we drops immediately (asynchronously), no write occurs, and no done is pulsed.
- Reads and writes to the same address by different requesters are serialized in grant order. A read granted after a write returns the written data.

Optional Feature:
- Macro RAMARB_FIXED_PRIO_EN.
- Defined: fixed priority. A always wins when both request; the last pointer is unused, and B can starve while A holds req.
- Undefined (default): round-robin as in Behaviour.

Test Plan:
- Preload RAM ram[0]=10'h005, ram[6]=10'h057. A reads addr 0 -> a_gnt at t+1; ram_address=0 and ram_we=0 at t+1; a_done and a_rdata=10'h005 at t+2; b_* outputs unchanged.
- B writes 10'h2AA to addr 25, then A reads addr 25 -> b_done pulse with ram_we high for exactly 1 cycle; later a_rdata=10'h2AA.
- A and B both hold req continuously, reading addrs 6 and 0 -> grants alternate A,B,A,B starting with A, every 2 cycles. a_rdata=10'h057, b_rdata=10'h005. Never two gnts in one cycle.
- Same stimulus with RAMARB_FIXED_PRIO_EN -> only A granted while a_req is high; B granted once A drops req.
- Assert reset during the ACCESS cycle of a B write of 10'h3FF to addr 7 (prior value 10'h061) -> ram_we falls immediately, no b_done; subsequent read of addr 7 returns 10'h061. All outputs 0 during reset.
- Back-to-back: A holds req with addr 8 then addr 9 after the first gnt -> two grants 2 cycles apart, two done pulses, rdata updates in order.
